// File: rtl/system_bus.sv
// system_bus: byte-wide memory-mapped interconnect for the aftab_core memory port.
//
// Every read or write is answered with a registered memDataReady pulse one cycle later.
//
// Address map:
//   RAM at 0x0000_0000 up to MEM_BYTES-1.
//   UART RX data, status and TX data at 0x0001_0000, 0x0001_0001 and 0x0001_0002.
//   32-bit timer at 0x0001_0010 (four bytes, little-endian).
//   Timer control at 0x0001_0014.
//   Read-only sensor constants at 0x0001_0020, 0x0001_0021 and 0x0001_0022.
//
// Ports:
//   clk, rst        system clock; synchronous active-high reset
//   readMem         core read request
//   writemem        core write request
//   addressBus      32-bit byte address
//   dataBusIn       write data from the core
//   to_embedded     UART RX serial line, idle high
//   dataBusOut      read data, registered
//   memDataReady    access-complete strobe, registered
//   uart_interrupt  high while a received byte is unread
//   from_embedded   UART TX serial line, idle high
module system_bus #(
    parameter int          CLKS_PER_BIT   = 86,
    parameter int          MEM_BYTES      = 4096,
    parameter string       INIT_FILE      = "program.hex",
    parameter logic [7:0]  TEMP_VALUE     = 8'h19,
    parameter logic [7:0]  HUMIDITY_VALUE = 8'h28,
    parameter logic [7:0]  FLS_VALUE      = 8'h01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        readMem,
    input  logic        writemem,
    input  logic [31:0] addressBus,
    input  logic [7:0]  dataBusIn,
    input  logic        to_embedded,
    output logic [7:0]  dataBusOut,
    output logic        memDataReady,
    output logic        uart_interrupt,
    output logic        from_embedded
);

    localparam int AW   = $clog2(MEM_BYTES);
    localparam int CW   = $clog2(CLKS_PER_BIT) + 1;
    localparam int HALF = CLKS_PER_BIT / 2;

    localparam logic [31:0] A_RX_DATA = 32'h0001_0000;
    localparam logic [31:0] A_STATUS  = 32'h0001_0001;
    localparam logic [31:0] A_TX_DATA = 32'h0001_0002;
    localparam logic [31:0] A_TMR_CTL = 32'h0001_0014;
    localparam logic [31:0] A_TEMP    = 32'h0001_0020;
    localparam logic [31:0] A_HUM     = 32'h0001_0021;
    localparam logic [31:0] A_FLS     = 32'h0001_0022;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic is_ram;
    logic ram_wr;
    logic stat_wr;
    logic tx_load;
    logic cnt_wr;
    logic ctl_wr;

    logic [7:0]  ram [MEM_BYTES];
    logic [7:0]  rd_data;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_busy;
    logic [31:0] timer;
    logic        tmr_en;

    assign is_ram  = (addressBus < 32'(MEM_BYTES));
    assign ram_wr  = writemem && is_ram;
    assign stat_wr = writemem && (addressBus == A_STATUS);
    assign tx_load = writemem && (addressBus == A_TX_DATA) && !tx_busy;
    // 0x0001_0010..0x0001_0013 share the same upper 30 address bits.
    assign cnt_wr  = writemem && (addressBus[31:2] == 30'h0000_4004);
    assign ctl_wr  = writemem && (addressBus == A_TMR_CTL);

    // ------------------------------------------------------------------
    // RAM (contents survive reset)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (ram_wr)
            ram[addressBus[AW-1:0]] <= dataBusIn;
    end

    // ------------------------------------------------------------------
    // Read mux and bus response
    // ------------------------------------------------------------------
    always_comb begin
        rd_data = 8'h00;
        if (is_ram) begin
            rd_data = ram[addressBus[AW-1:0]];
        end else begin
            case (addressBus)
                A_RX_DATA:     rd_data = rx_data;
                A_STATUS:      rd_data = {6'b0, tx_busy, rx_valid};
                32'h0001_0010: rd_data = timer[7:0];
                32'h0001_0011: rd_data = timer[15:8];
                32'h0001_0012: rd_data = timer[23:16];
                32'h0001_0013: rd_data = timer[31:24];
                A_TMR_CTL:     rd_data = {7'b0, tmr_en};
                A_TEMP:        rd_data = TEMP_VALUE;
                A_HUM:         rd_data = HUMIDITY_VALUE;
                A_FLS:         rd_data = FLS_VALUE;
                default:       rd_data = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dataBusOut   <= 8'h00;
            memDataReady <= 1'b0;
        end else begin
            memDataReady <= readMem | writemem;
            // A simultaneous write takes priority and the read data is held.
            if (readMem && !writemem)
                dataBusOut <= rd_data;
        end
    end

    // ------------------------------------------------------------------
    // Timer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            timer  <= 32'h0;
            tmr_en <= 1'b0;
        end else begin
            if (ctl_wr)
                tmr_en <= dataBusIn[0];
            // A byte write freezes the count for that cycle.
            if (cnt_wr)
                timer[{addressBus[1:0], 3'b000} +: 8] <= dataBusIn;
            else if (tmr_en)
                timer <= timer + 32'd1;
        end
    end

    // ------------------------------------------------------------------
    // UART receiver
    // ------------------------------------------------------------------
    uart_state_t   rx_state;
    logic          rx_meta;
    logic          rx_s;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta  <= 1'b1;
            rx_s     <= 1'b1;
            rx_state <= IDLE;
            rx_cnt   <= '0;
            rx_bit   <= 3'd0;
            rx_shift <= 8'h00;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
        end else begin
            rx_meta <= to_embedded;
            rx_s    <= rx_meta;
            // Clear first so a byte completing in the same cycle wins.
            if (stat_wr)
                rx_valid <= 1'b0;
            case (rx_state)
                IDLE: begin
                    if (!rx_s) begin
                        rx_state <= START;
                        rx_cnt   <= '0;
                    end
                end
                START: begin
                    if (rx_cnt == CW'(HALF - 1)) begin
                        rx_cnt <= '0;
                        rx_bit <= 3'd0;
                        // Line back high at mid-start: treat as a glitch.
                        rx_state <= rx_s ? IDLE : DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        if (rx_bit == 3'd7)
                            rx_state <= STOP;
                        else
                            rx_bit <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (rx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        rx_cnt   <= '0;
                        rx_state <= IDLE;
                        // A low stop bit is a framing error; drop the byte.
                        if (rx_s) begin
                            rx_data  <= rx_shift;
                            rx_valid <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                default: rx_state <= IDLE;
            endcase
        end
    end

    assign uart_interrupt = rx_valid;

    // ------------------------------------------------------------------
    // UART transmitter
    // ------------------------------------------------------------------
    uart_state_t   tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state      <= IDLE;
            tx_cnt        <= '0;
            tx_bit        <= 3'd0;
            tx_shift      <= 8'h00;
            tx_busy       <= 1'b0;
            from_embedded <= 1'b1;
        end else begin
            case (tx_state)
                IDLE: begin
                    if (tx_load) begin
                        tx_shift      <= dataBusIn;
                        tx_busy       <= 1'b1;
                        tx_cnt        <= '0;
                        from_embedded <= 1'b0;
                        tx_state      <= START;
                    end
                end
                START: begin
                    if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        tx_cnt        <= '0;
                        tx_bit        <= 3'd0;
                        from_embedded <= tx_shift[0];
                        tx_shift      <= {1'b0, tx_shift[7:1]};
                        tx_state      <= DATA;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        tx_cnt <= '0;
                        if (tx_bit == 3'd7) begin
                            from_embedded <= 1'b1;
                            tx_state      <= STOP;
                        end else begin
                            from_embedded <= tx_shift[0];
                            tx_shift      <= {1'b0, tx_shift[7:1]};
                            tx_bit        <= tx_bit + 3'd1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (tx_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        tx_cnt   <= '0;
                        tx_busy  <= 1'b0;
                        tx_state <= IDLE;
                    end else begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end
                end
                default: tx_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_system_bus.sv
// tb_system_bus: self-checking bench for system_bus. Random bus traffic is
// checked against an associative-array memory model; UART and timer behaviour
// is checked against frame/cycle arithmetic.
module tb_system_bus;

    localparam int CPB       = 86;
    localparam int MEM_BYTES = 4096;
    localparam int BIT_T     = CPB * 100;   // clock period is 100 time units

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        readMem = 1'b0;
    logic        writemem = 1'b0;
    logic [31:0] addressBus = 32'h0;
    logic [7:0]  dataBusIn = 8'h00;
    logic        to_embedded = 1'b1;
    logic [7:0]  dataBusOut;
    logic        memDataReady;
    logic        uart_interrupt;
    logic        from_embedded;

    int total = 0;
    int bad   = 0;

    logic [7:0] ram_m [int];
    logic [7:0] last_out = 8'h00;

    system_bus #(
        .CLKS_PER_BIT(CPB),
        .MEM_BYTES(MEM_BYTES),
        .INIT_FILE(""),
        .TEMP_VALUE(8'h19),
        .HUMIDITY_VALUE(8'h28),
        .FLS_VALUE(8'h01)
    ) dut (
        .clk(clk),
        .rst(rst),
        .readMem(readMem),
        .writemem(writemem),
        .addressBus(addressBus),
        .dataBusIn(dataBusIn),
        .to_embedded(to_embedded),
        .dataBusOut(dataBusOut),
        .memDataReady(memDataReady),
        .uart_interrupt(uart_interrupt),
        .from_embedded(from_embedded)
    );

    always #50 clk = ~clk;

    // Bus drivers: called at a negedge, return at the negedge after the sampling edge.
    task automatic do_write(input logic [31:0] a, input logic [7:0] d);
        addressBus = a; dataBusIn = d; writemem = 1'b1; readMem = 1'b0;
        @(negedge clk);
        writemem = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [7:0] d, output logic rdy);
        addressBus = a; readMem = 1'b1; writemem = 1'b0;
        @(negedge clk);
        readMem = 1'b0;
        d = dataBusOut;
        rdy = memDataReady;
    endtask

    task automatic send_frame(input logic [7:0] b, input int start_t, input int stop_t,
                              input logic stop_val);
        to_embedded = 1'b0;
        #(start_t);
        for (int i = 0; i < 8; i++) begin
            to_embedded = b[i];
            #(BIT_T);
        end
        to_embedded = stop_val;
        #(stop_t);
        to_embedded = 1'b1;
    endtask

    function automatic logic [7:0] periph_model(input logic [31:0] a);
        case (a)
            32'h0001_0020: return 8'h19;
            32'h0001_0021: return 8'h28;
            32'h0001_0022: return 8'h01;
            default:       return 8'h00;
        endcase
    endfunction

    task automatic test_reset;
        logic [7:0] d;
        logic       r;
        logic [31:0] sens [3];
        logic [7:0]  sexp [3];
        sens[0] = 32'h0001_0020; sens[1] = 32'h0001_0021; sens[2] = 32'h0001_0022;
        sexp[0] = 8'h19; sexp[1] = 8'h28; sexp[2] = 8'h01;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({dataBusOut, memDataReady, uart_interrupt, from_embedded} !== {8'h00, 1'b0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_outputs: got out=%h rdy=%b irq=%b tx=%b want 00 0 0 1",
                     dataBusOut, memDataReady, uart_interrupt, from_embedded);
        end
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            do_read(sens[i], d, r);
            total++;
            if (d !== sexp[i] || r !== 1'b1) begin
                bad++;
                $display("FAIL sensor_read[%0d]: got %h rdy=%b want %h rdy=1", i, d, r, sexp[i]);
            end
            @(negedge clk);
            total++;
            if (memDataReady !== 1'b0) begin
                bad++;
                $display("FAIL ready_pulse[%0d]: got %b want 0", i, memDataReady);
            end
        end
        do_read(32'h0001_0001, d, r);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL reset_status: got %h want 00", d); end
        do_read(32'h0001_0010, d, r);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL reset_timer: got %h want 00", d); end
        last_out = d;
    endtask

    task automatic test_random_bus;
        logic [7:0]  d, got;
        logic        r;
        logic [31:0] a, ua;
        int          op;
        for (int n = 0; n < 160; n++) begin
            op = $urandom_range(0, 4);
            a  = ($urandom_range(0, 7) == 0) ? 32'(MEM_BYTES - 1) : 32'($urandom_range(0, 255));
            d  = 8'($urandom);
            case (op)
                0: begin
                    do_write(a, d);
                    ram_m[int'(a)] = d;
                    total++;
                    if (memDataReady !== 1'b1) begin bad++; $display("FAIL wr_ready: got %b want 1", memDataReady); end
                end
                1: begin
                    if (ram_m.exists(int'(a))) begin
                        do_read(a, got, r);
                        total++;
                        if (got !== ram_m[int'(a)] || r !== 1'b1) begin
                            bad++;
                            $display("FAIL ram_read @%h: got %h rdy=%b want %h", a, got, r, ram_m[int'(a)]);
                        end
                        last_out = ram_m[int'(a)];
                    end else begin
                        @(negedge clk);
                    end
                end
                2: begin
                    // Unmapped write: may alias RAM if decode is partial.
                    if ($urandom_range(0, 1) == 0)
                        ua = {16'($urandom_range(2, 65535)), 16'(a)};
                    else
                        ua = 32'(MEM_BYTES) + (a & 32'hFF);
                    do_write(ua, d);
                    total++;
                    if (memDataReady !== 1'b1) begin bad++; $display("FAIL unmapped_wr_ready: got %b want 1", memDataReady); end
                end
                3: begin
                    case ($urandom_range(0, 5))
                        0: ua = 32'h0001_0020;
                        1: ua = 32'h0001_0021;
                        2: ua = 32'h0001_0022;
                        3: ua = 32'h0001_0003 + 32'($urandom_range(0, 12));
                        4: ua = 32'h0002_0000 | 32'($urandom_range(0, 65535));
                        default: ua = 32'(MEM_BYTES) + 32'($urandom_range(0, 255));
                    endcase
                    do_read(ua, got, r);
                    total++;
                    if (got !== periph_model(ua) || r !== 1'b1) begin
                        bad++;
                        $display("FAIL periph_read @%h: got %h rdy=%b want %h", ua, got, r, periph_model(ua));
                    end
                    last_out = periph_model(ua);
                end
                default: begin
                    addressBus = a; dataBusIn = d; readMem = 1'b1; writemem = 1'b1;
                    @(negedge clk);
                    readMem = 1'b0; writemem = 1'b0;
                    ram_m[int'(a)] = d;
                    total++;
                    if (dataBusOut !== last_out || memDataReady !== 1'b1) begin
                        bad++;
                        $display("FAIL rw_both_hold: got %h rdy=%b want %h", dataBusOut, memDataReady, last_out);
                    end
                end
            endcase
        end
        do_read(32'h0002_0000, got, r);
        total++;
        if (got !== 8'h00 || r !== 1'b1) begin bad++; $display("FAIL unmapped_20000: got %h rdy=%b want 00", got, r); end
        foreach (ram_m[k]) begin
            do_read(32'(k), got, r);
            total++;
            if (got !== ram_m[k]) begin bad++; $display("FAIL ram_sweep @%h: got %h want %h", k, got, ram_m[k]); end
        end
    endtask

    task automatic test_timer;
        logic [7:0]  a, b;
        logic        r;
        logic [31:0] v, want;
        int          n;
        do_write(32'h0001_0014, 8'h01);
        for (int k = 0; k < 2; k++) begin
            n = (k == 0) ? 10 : $urandom_range(3, 40);
            do_read(32'h0001_0010, a, r);
            repeat (n - 1) @(negedge clk);
            do_read(32'h0001_0010, b, r);
            total++;
            if (8'(b - a) !== 8'(n)) begin bad++; $display("FAIL timer_delta n=%0d: got %0d want %0d", n, 8'(b - a), n); end
        end
        for (int i = 0; i < 4; i++) do_write(32'h0001_0010 + 32'(i), 8'hFF);
        @(negedge clk);
        do_write(32'h0001_0014, 8'h00);   // counter has advanced twice past all-ones
        for (int i = 0; i < 4; i++) begin
            do_read(32'h0001_0010 + 32'(i), b, r);
            v[8*i +: 8] = b;
        end
        total++;
        if (v !== 32'h0000_0001) begin bad++; $display("FAIL timer_wrap: got %h want 00000001", v); end
        do_read(32'h0001_0014, b, r);
        total++;
        if (b !== 8'h00) begin bad++; $display("FAIL timer_ctl: got %h want 00", b); end
        want = $urandom;
        for (int i = 0; i < 4; i++) do_write(32'h0001_0010 + 32'(i), want[8*i +: 8]);
        repeat (5) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            do_read(32'h0001_0010 + 32'(i), b, r);
            v[8*i +: 8] = b;
        end
        total++;
        if (v !== want) begin bad++; $display("FAIL timer_load_hold: got %h want %h", v, want); end
        last_out = b;
    endtask

    task automatic test_uart_rx;
        logic [7:0] d, b, b2;
        logic       r;
        send_frame(8'h3C, 9600, BIT_T, 1'b1);
        @(negedge clk);
        total++;
        if (uart_interrupt !== 1'b1) begin bad++; $display("FAIL rx_irq: got %b want 1", uart_interrupt); end
        do_read(32'h0001_0000, d, r);
        total++;
        if (d !== 8'h3C) begin bad++; $display("FAIL rx_data: got %h want 3c", d); end
        do_read(32'h0001_0001, d, r);
        total++;
        if (d !== 8'h01) begin bad++; $display("FAIL rx_status: got %h want 01", d); end
        do_write(32'h0001_0001, 8'h00);
        total++;
        if (uart_interrupt !== 1'b0) begin bad++; $display("FAIL irq_clear: got %b want 0", uart_interrupt); end
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            send_frame(b, BIT_T, BIT_T, 1'b1);
            @(negedge clk);
            do_read(32'h0001_0000, d, r);
            total++;
            if (d !== b || uart_interrupt !== 1'b1) begin
                bad++;
                $display("FAIL rx_rand[%0d]: got %h irq=%b want %h irq=1", k, d, uart_interrupt, b);
            end
            do_write(32'h0001_0001, 8'h00);
        end
        // Overwrite an unread byte.
        b = 8'($urandom); b2 = 8'($urandom);
        send_frame(b, BIT_T, BIT_T, 1'b1);
        send_frame(b2, BIT_T, BIT_T, 1'b1);
        @(negedge clk);
        do_read(32'h0001_0000, d, r);
        total++;
        if (d !== b2) begin bad++; $display("FAIL rx_overwrite: got %h want %h", d, b2); end
        do_read(32'h0001_0001, d, r);
        total++;
        if (d !== 8'h01) begin bad++; $display("FAIL rx_overwrite_status: got %h want 01", d); end
        do_write(32'h0001_0001, 8'hFF);
        // Short glitch on the line must not start a reception.
        to_embedded = 1'b0;
        #1000;
        to_embedded = 1'b1;
        repeat (1200) @(negedge clk);
        total++;
        if (uart_interrupt !== 1'b0) begin bad++; $display("FAIL rx_glitch: got irq=%b want 0", uart_interrupt); end
        // Framing error: low stop bit, released shortly after mid-stop.
        send_frame(8'h5A, BIT_T, 5500, 1'b0);
        repeat (300) @(negedge clk);
        do_read(32'h0001_0000, d, r);
        total++;
        if (uart_interrupt !== 1'b0 || d !== b2) begin
            bad++;
            $display("FAIL rx_framing: got irq=%b data=%h want irq=0 data=%h", uart_interrupt, d, b2);
        end
        last_out = d;
    endtask

    task automatic test_uart_tx;
        logic [9:0] fr;
        logic [7:0] b, d;
        logic       r, expv;
        for (int rep = 0; rep < 2; rep++) begin
            b  = (rep == 0) ? 8'h55 : 8'($urandom);
            fr = {1'b1, b, 1'b0};
            do_write(32'h0001_0002, b);
            for (int j = 0; j <= 10 * CPB; j++) begin
                expv = (j < 10 * CPB) ? fr[j / CPB] : 1'b1;
                total++;
                if (from_embedded !== expv) begin
                    bad++;
                    $display("FAIL tx_line[%0d] cyc=%0d: got %b want %b", rep, j, from_embedded, expv);
                end
                if (rep == 0 && j == 100) begin
                    addressBus = 32'h0001_0002; dataBusIn = 8'hAA; writemem = 1'b1;
                end else if (rep == 0 && j == 200) begin
                    addressBus = 32'h0001_0001; readMem = 1'b1;
                end else begin
                    writemem = 1'b0; readMem = 1'b0;
                end
                @(negedge clk);
                if (rep == 0 && j == 200) begin
                    total++;
                    if (dataBusOut[1] !== 1'b1) begin bad++; $display("FAIL tx_busy_flag: got %b want 1", dataBusOut[1]); end
                end
            end
            writemem = 1'b0; readMem = 1'b0;
            do_read(32'h0001_0001, d, r);
            total++;
            if (d[1] !== 1'b0) begin bad++; $display("FAIL tx_busy_clear[%0d]: got %b want 0", rep, d[1]); end
        end
    endtask

    task automatic test_reset_mid_rx;
        logic [7:0] d, b;
        logic       r;
        fork
            send_frame(8'hFF, BIT_T, BIT_T, 1'b1);
            begin
                repeat (4 * CPB) @(negedge clk);
                rst = 1'b1;
                repeat (2) @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (200) @(negedge clk);
        total++;
        if (uart_interrupt !== 1'b0 || from_embedded !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_rx: got irq=%b tx=%b want 0 1", uart_interrupt, from_embedded);
        end
        do_read(32'h0001_0001, d, r);
        total++;
        if (d !== 8'h00) begin bad++; $display("FAIL rst_mid_rx_status: got %h want 00", d); end
        b = 8'($urandom);
        send_frame(b, BIT_T, BIT_T, 1'b1);
        @(negedge clk);
        do_read(32'h0001_0000, d, r);
        total++;
        if (d !== b || uart_interrupt !== 1'b1) begin
            bad++;
            $display("FAIL rx_after_rst: got %h irq=%b want %h irq=1", d, uart_interrupt, b);
        end
    endtask

    initial begin
        test_reset();
        test_random_bus();
        test_timer();
        test_uart_rx();
        test_uart_tx();
        test_reset_mid_rx();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
